// File: rtl/riscv_csr_counters.sv
// Counter/timer CSR unit: cycle, time, instret and optional hpm event counters
// behind a single-request CSR port with a registered one-cycle response.
// Optional feature macro: RISCV_CSR_HPM_EN (builds the hpm event counters).
module riscv_csr_counters #(
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned HPM_NUM       = 4,
  parameter int unsigned TIME_DIV      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_retired,
  input  logic [HPM_NUM-1:0] hpm_event,
  input  logic               csr_valid,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_ready,
  output logic               csr_error
);

  localparam int unsigned HI_W = COUNTER_WIDTH - 32;
`ifdef RISCV_CSR_HPM_EN
  localparam int unsigned NUM_CNT = 3 + HPM_NUM;
`else
  localparam int unsigned NUM_CNT = 3;
`endif
  localparam int unsigned IDX_TIME  = 1;
  localparam logic [1:0]  OP_WRITE  = 2'b01;
  localparam logic [1:0]  OP_SET    = 2'b10;
  localparam logic [1:0]  OP_CLEAR  = 2'b11;
  localparam logic [3:0]  PAGE_USER = 4'hC;
  localparam logic [3:0]  PAGE_MACH = 4'hB;

  logic [31:0]              presc_q;
  logic                     time_tick_c;
  logic [3:0]               page_c;
  logic                     hi_c;
  logic [4:0]               off_c;
  logic                     mapped_c;
  logic                     wr_req_c;
  logic                     err_c;
  logic                     do_wr_c;
  logic [COUNTER_WIDTH-1:0] sel_cnt_c;
  logic [31:0]              old_half_c;
  logic [31:0]              new_half_c;
  logic [NUM_CNT:0][COUNTER_WIDTH-1:0] sel_chain_c;

`ifndef RISCV_CSR_HPM_EN
  logic unused_hpm_event;
  assign unused_hpm_event = ^hpm_event;
`endif

  // time prescaler: time advances on the edge where the prescaler wraps to 0
  assign time_tick_c = (presc_q == 32'(TIME_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (time_tick_c) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 32'd1;
    end
  end

  // address decode and access legality
  always_comb begin
    page_c   = csr_addr[11:8];
    hi_c     = csr_addr[7];
    off_c    = csr_addr[4:0];
    mapped_c = ((page_c == PAGE_USER) || (page_c == PAGE_MACH)) &&
               (csr_addr[6:5] == 2'b00) &&
               (32'(off_c) < NUM_CNT) &&
               !((page_c == PAGE_MACH) && (32'(off_c) == IDX_TIME));
    wr_req_c = (csr_op == OP_WRITE) || (csr_op[1] && (csr_wdata != 32'd0));
    err_c    = !mapped_c || ((page_c == PAGE_USER) && wr_req_c);
    do_wr_c  = csr_valid && !err_c && wr_req_c;
  end

  assign sel_chain_c[0] = '0;

  // one counter per generate slice; slice g also extends the read-select chain
  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic                     hit_c;
    logic                     wr_c;
    logic                     inc_c;

    assign hit_c              = (32'(off_c) == 32'(g));
    assign wr_c               = do_wr_c && hit_c;
    assign sel_chain_c[g + 1] = hit_c ? cnt_q : sel_chain_c[g];

    if (g == 0) begin : g_inc_cycle
      assign inc_c = 1'b1;
    end else if (g == 1) begin : g_inc_time
      assign inc_c = time_tick_c;
    end else if (g == 2) begin : g_inc_instret
      assign inc_c = instr_retired;
    end else begin : g_inc_hpm
      assign inc_c = hpm_event[g - 3];
    end

    // a successful write replaces one half and suppresses this cycle's increment
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (wr_c) begin
        if (hi_c) begin
          cnt_q[COUNTER_WIDTH-1:32] <= new_half_c[HI_W-1:0];
        end else begin
          cnt_q[31:0] <= new_half_c;
        end
      end else if (inc_c) begin
        cnt_q <= cnt_q + COUNTER_WIDTH'(1);
      end
    end
  end

  // old half value and the read/modify/write result
  always_comb begin
    sel_cnt_c  = sel_chain_c[NUM_CNT];
    old_half_c = hi_c ? 32'(sel_cnt_c[COUNTER_WIDTH-1:32]) : sel_cnt_c[31:0];
    case (csr_op)
      OP_WRITE: new_half_c = csr_wdata;
      OP_SET:   new_half_c = old_half_c | csr_wdata;
      OP_CLEAR: new_half_c = old_half_c & ~csr_wdata;
      default:  new_half_c = old_half_c;
    endcase
  end

  // registered response; data and error hold between requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_ready <= 1'b0;
      csr_rdata <= '0;
      csr_error <= 1'b0;
    end else begin
      csr_ready <= csr_valid;
      if (csr_valid) begin
        csr_error <= err_c;
        csr_rdata <= err_c ? 32'd0 : old_half_c;
      end
    end
  end

endmodule

// File: tb/tb_riscv_csr_counters.sv
// Self-checking bench for riscv_csr_counters: directed steps plus random
// traffic against a table-driven counter model.
module tb_riscv_csr_counters;

  localparam int unsigned CW = 64;
  localparam int unsigned HN = 4;
  localparam int unsigned TD = 10;
`ifdef RISCV_CSR_HPM_EN
  localparam int unsigned NCTR = 3 + HN;
`else
  localparam int unsigned NCTR = 3;
`endif
  localparam logic [63:0] CNT_MASK = (CW >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);
  localparam logic [31:0] HI_MASK  = (CW >= 64) ? 32'hFFFF_FFFF : 32'((64'd1 << (CW - 32)) - 64'd1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_retired;
  logic [HN-1:0] hpm_event;
  logic          csr_valid;
  logic [11:0]   csr_addr;
  logic [1:0]    csr_op;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          csr_ready;
  logic          csr_error;

  always #5 clk = ~clk;

  riscv_csr_counters #(.COUNTER_WIDTH(CW), .HPM_NUM(HN), .TIME_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .instr_retired(instr_retired), .hpm_event(hpm_event),
    .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_ready(csr_ready), .csr_error(csr_error)
  );

  logic [63:0] m_cnt [32];
  int unsigned m_presc;
  logic [31:0] last_rdata;
  logic        last_error;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // enumerate the architectural address map counter by counter
  function automatic void lookup(input logic [11:0] a, output bit found, output logic [4:0] idx,
                                 output bit hi, output bit user);
    found = 1'b0; idx = '0; hi = 1'b0; user = 1'b0;
    for (int i = 0; i < int'(NCTR); i++) begin
      if (a == 12'(32'hC00 + i)) begin found = 1'b1; idx = 5'(i); hi = 1'b0; user = 1'b1; end
      if (a == 12'(32'hC80 + i)) begin found = 1'b1; idx = 5'(i); hi = 1'b1; user = 1'b1; end
      if (i != 1 && a == 12'(32'hB00 + i)) begin found = 1'b1; idx = 5'(i); hi = 1'b0; user = 1'b0; end
      if (i != 1 && a == 12'(32'hB80 + i)) begin found = 1'b1; idx = 5'(i); hi = 1'b1; user = 1'b0; end
    end
  endfunction

  function automatic logic [31:0] modify(input logic [1:0] op, input logic [31:0] old,
                                         input logic [31:0] wd);
    case (op)
      2'b01:   return wd;
      2'b10:   return old | wd;
      2'b11:   return old & ~wd;
      default: return old;
    endcase
  endfunction

  // one clock: drive at posedge+1, update the model at the edge, check at posedge+1
  task automatic step(input bit v, input logic [11:0] a, input logic [1:0] op,
                      input logic [31:0] wd, input bit ret, input logic [HN-1:0] ev,
                      input string tag);
    bit found, hi, user, wr, err, inc;
    logic [4:0]  idx;
    logic [31:0] old_half, nh;
    csr_valid = v; csr_addr = a; csr_op = op; csr_wdata = wd;
    instr_retired = ret; hpm_event = ev;
    lookup(a, found, idx, hi, user);
    wr  = (op == 2'b01) || (op[1] && (wd != 32'd0));
    err = !found || (user && wr);
    old_half = hi ? m_cnt[idx][63:32] : m_cnt[idx][31:0];
    @(posedge clk);
    m_presc = (m_presc + 1) % TD;
    for (int i = 0; i < int'(NCTR); i++) begin
      if (i == 0)      inc = 1'b1;
      else if (i == 1) inc = (m_presc == 0);
      else if (i == 2) inc = ret;
      else             inc = |(ev & (HN'(1) << (i - 3)));
      if (v && !err && wr && idx == 5'(i)) begin
        nh = modify(op, old_half, wd);
        if (hi) m_cnt[i][63:32] = nh & HI_MASK;
        else    m_cnt[i][31:0]  = nh;
      end else if (inc) begin
        m_cnt[i] = (m_cnt[i] + 64'd1) & CNT_MASK;
      end
    end
    if (v) begin
      last_rdata = err ? 32'd0 : old_half;
      last_error = err;
    end
    #1;
    chk({tag, ".ready"}, 32'(csr_ready), 32'(v));
    chk({tag, ".rdata"}, csr_rdata, last_rdata);
    chk({tag, ".error"}, 32'(csr_error), 32'(last_error));
  endtask

  task automatic idle(input int n, input bit ret);
    for (int k = 0; k < n; k++) step(1'b0, 12'h000, 2'b00, 32'd0, ret, '0, "idle");
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 64'd0;
    m_presc = 0; last_rdata = 32'd0; last_error = 1'b0;
  endtask

  // asynchronous reset in mid-cycle aborts a pending response at once
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    csr_valid = 1'b0;
    #1;
    chk("areset.ready", 32'(csr_ready), 32'd0);
    chk("areset.rdata", csr_rdata, 32'd0);
    chk("areset.error", 32'(csr_error), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] a;
    logic [11:0] base;
    rst_n = 1'b0; instr_retired = 1'b0; hpm_event = '0;
    csr_valid = 1'b0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
    model_reset();
    @(posedge clk); #1;
    chk("reset.ready", 32'(csr_ready), 32'd0);
    chk("reset.rdata", csr_rdata, 32'd0);
    chk("reset.error", 32'(csr_error), 32'd0);
    rst_n = 1'b1;

    // cycle count: read at the 10th edge returns the pre-edge value 9
    idle(9, 1'b0);
    step(1'b1, 12'hC00, 2'b00, 32'd0, 1'b0, '0, "cycle_lo");
    chk("cycle_at_10", csr_rdata, 32'd9);
    step(1'b1, 12'hC80, 2'b00, 32'd0, 1'b0, '0, "cycle_hi");
    chk("cycle_hi_zero", csr_rdata, 32'd0);

    // time prescaler and illegal write to time
    apply_reset();
    idle(100, 1'b0);
    step(1'b1, 12'hC01, 2'b00, 32'd0, 1'b0, '0, "time_rd");
    chk("time_after_100", csr_rdata, 32'd10);
    step(1'b1, 12'hC01, 2'b01, 32'd5, 1'b0, '0, "time_wr");
    chk("time_wr_error", 32'(csr_error), 32'd1);
    step(1'b1, 12'hB01, 2'b00, 32'd0, 1'b0, '0, "time_alias");
    step(1'b1, 12'hC01, 2'b00, 32'd0, 1'b0, '0, "time_rd2");

    // carry from the low half into the high half
    step(1'b1, 12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b0, '0, "mcycle_lo_wr");
    step(1'b1, 12'hB80, 2'b01, 32'd0, 1'b0, '0, "mcycle_hi_wr");
    idle(1, 1'b0);
    step(1'b1, 12'hC80, 2'b00, 32'd0, 1'b0, '0, "carry_hi");
    chk("carry_hi_one", csr_rdata, 32'd1);
    step(1'b1, 12'hC00, 2'b00, 32'd0, 1'b0, '0, "carry_lo");

    // write vs increment collision on instret
    step(1'b1, 12'hB02, 2'b01, 32'h100, 1'b1, '0, "minstret_wr");
    idle(1, 1'b1);
    step(1'b1, 12'hC02, 2'b00, 32'd0, 1'b1, '0, "instret_rd");
    chk("collision_101", csr_rdata, 32'h101);
    step(1'b1, 12'hC82, 2'b00, 32'd0, 1'b0, '0, "instret_hi");

    // set / clear / zero-operand set
    step(1'b1, 12'hB02, 2'b01, 32'hF0, 1'b0, '0, "sc_wr");
    step(1'b1, 12'hB02, 2'b10, 32'h0F, 1'b0, '0, "sc_set");
    step(1'b1, 12'hB02, 2'b00, 32'd0, 1'b0, '0, "sc_rd1");
    chk("set_ff", csr_rdata, 32'hFF);
    step(1'b1, 12'hB02, 2'b11, 32'h30, 1'b0, '0, "sc_clr");
    step(1'b1, 12'hB02, 2'b00, 32'd0, 1'b0, '0, "sc_rd2");
    chk("clear_cf", csr_rdata, 32'hCF);
    step(1'b1, 12'hC02, 2'b10, 32'd0, 1'b1, '0, "sc_set0");
    chk("set0_no_error", 32'(csr_error), 32'd0);
    step(1'b1, 12'hB02, 2'b00, 32'd0, 1'b0, '0, "sc_rd3");
    chk("set0_inc_kept", csr_rdata, 32'hD0);

    // hpm bounds
`ifdef RISCV_CSR_HPM_EN
    step(1'b1, 12'hC06, 2'b00, 32'd0, 1'b0, 4'b1001, "hpm6");
    chk("hpm6_valid", 32'(csr_error), 32'd0);
    step(1'b1, 12'hC07, 2'b00, 32'd0, 1'b0, 4'b1111, "hpm7");
    chk("hpm7_error", 32'(csr_error), 32'd1);
    step(1'b1, 12'hB03, 2'b01, 32'h55, 1'b0, 4'b0001, "mhpm3_wr");
    step(1'b1, 12'hC03, 2'b00, 32'd0, 1'b0, 4'b0001, "hpm3_rd");
`else
    step(1'b1, 12'hC03, 2'b00, 32'd0, 1'b0, 4'b1111, "hpm3");
    chk("hpm3_error", 32'(csr_error), 32'd1);
    step(1'b1, 12'hB03, 2'b01, 32'h55, 1'b0, 4'b1111, "mhpm3_wr");
    chk("mhpm3_error", 32'(csr_error), 32'd1);
`endif
    step(1'b1, 12'hD00, 2'b00, 32'd0, 1'b0, '0, "unmapped");
    chk("unmapped_error", 32'(csr_error), 32'd1);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0:       base = 12'hC00;
        1:       base = 12'hC80;
        2:       base = 12'hB00;
        3:       base = 12'hB80;
        default: base = 12'($urandom);
      endcase
      a = base + 12'($urandom_range(0, 9));
      step($urandom_range(0, 3) != 0, a, 2'($urandom),
           ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
           1'($urandom), HN'($urandom), "rand");
    end

    step(1'b1, 12'hC00, 2'b00, 32'd0, 1'b0, '0, "pre_reset_rd");
    apply_reset();
    step(1'b1, 12'hC00, 2'b00, 32'd0, 1'b0, '0, "post_reset_rd");
    chk("post_reset_cycle", csr_rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
